// File: rtl/mem_stage_sram_pkg.sv
// Shared types and constants for the MEM stage and its 16-bit SRAM word controller.
package mem_stage_sram_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } sram_state_t;

  localparam int unsigned ADDR_BASE_DEF = 1024;
  localparam int unsigned SRAM_DQ_W     = 16;
  localparam int unsigned SRAM_WORD_W   = 2 * SRAM_DQ_W;
  localparam int unsigned WAIT_CNT_W    = 4;

  // Control half of the WB payload; the wide fields are kept in separate registers.
  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic [3:0] dest;
  } wb_ctrl_t;

endpackage

// File: rtl/mem_stage_sram_if.sv
// SRAM pin bundle: master is the MEM stage controller, slave is the memory device.
interface mem_stage_sram_if #(
  parameter int unsigned ADDR_W = 18
) ();
  import mem_stage_sram_pkg::*;

  logic [ADDR_W-1:0]    sram_addr;
  logic [SRAM_DQ_W-1:0] sram_dq_out;
  logic                 sram_dq_oe;
  logic [SRAM_DQ_W-1:0] sram_dq_in;
  logic                 sram_we_n;

  modport master (
    output sram_addr, sram_dq_out, sram_dq_oe, sram_we_n,
    input  sram_dq_in
  );

  modport slave (
    input  sram_addr, sram_dq_out, sram_dq_oe, sram_we_n,
    output sram_dq_in
  );
endinterface

// File: rtl/mem_stage_sram_word_ctrl.sv
// Two-half-word SRAM access sequencer: FSM, wait counter, registered pins, assembled read word.
module mem_stage_sram_word_ctrl
  import mem_stage_sram_pkg::*;
#(
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   write,
  input  logic [SRAM_ADDR_W-2:0] word,
  input  logic [SRAM_WORD_W-1:0] wdata,
  output logic                   done_c,
  output logic [SRAM_WORD_W-1:0] rdata,
  mem_stage_sram_if.master       sram
);

  localparam int unsigned WORD_AW = SRAM_ADDR_W - 1;

  sram_state_t state, state_next;

  logic [WAIT_CNT_W-1:0]  cnt, cnt_d;
  logic                   last_c;
  logic                   write_q, write_d, write_eff;
  logic [WORD_AW-1:0]     word_q, word_d, word_eff;
  logic [SRAM_WORD_W-1:0] wdata_q, wdata_d, wdata_eff;
  logic [SRAM_WORD_W-1:0] rdata_q, rdata_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [SRAM_DQ_W-1:0]   dq_q, dq_d;
  logic                   oe_q, oe_d, we_n_q, we_n_d;

  assign last_c = (cnt == WAIT_CNT_W'(WAIT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start)  state_next = S_LO;
      S_LO:    if (last_c) state_next = S_HI;
      S_HI:    if (last_c) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Pins are registered from the next state so they line up exactly with LO/HI.
  always_comb begin
    cnt_d     = cnt;
    write_d   = write_q;
    word_d    = word_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    dq_d      = dq_q;
    oe_d      = 1'b0;
    we_n_d    = 1'b1;
    write_eff = (state == S_IDLE) ? write : write_q;
    word_eff  = (state == S_IDLE) ? word  : word_q;
    wdata_eff = (state == S_IDLE) ? wdata : wdata_q;

    case (state)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          write_d = write;
          word_d  = word;
          wdata_d = wdata;
        end
      end
      S_LO, S_HI: begin
        cnt_d = last_c ? '0 : cnt + WAIT_CNT_W'(1);
        if (last_c && !write_q) begin
          if (state == S_LO) rdata_d[SRAM_DQ_W-1:0]           = sram.sram_dq_in;
          else               rdata_d[SRAM_WORD_W-1:SRAM_DQ_W] = sram.sram_dq_in;
        end
      end
      default: cnt_d = '0;
    endcase

    if (state_next == S_LO || state_next == S_HI) begin
      addr_d = {word_eff, state_next == S_HI};
      dq_d   = (state_next == S_HI) ? wdata_eff[SRAM_WORD_W-1:SRAM_DQ_W]
                                    : wdata_eff[SRAM_DQ_W-1:0];
      oe_d   = write_eff;
      we_n_d = !write_eff;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      write_q <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      dq_q    <= '0;
      oe_q    <= 1'b0;
      we_n_q  <= 1'b1;
    end else begin
      cnt     <= cnt_d;
      write_q <= write_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      dq_q    <= dq_d;
      oe_q    <= oe_d;
      we_n_q  <= we_n_d;
    end
  end

  assign done_c           = (state == S_DONE);
  assign rdata            = rdata_q;
  assign sram.sram_addr   = addr_q;
  assign sram.sram_dq_out = dq_q;
  assign sram.sram_dq_oe  = oe_q;
  assign sram.sram_we_n   = we_n_q;

endmodule

// File: rtl/mem_stage_sram.sv
// ARM pipeline MEM stage on a 16-bit SRAM: freeze, address translation, WB registers.
// Define MEM_ALIGN_CHECK_EN to reject unaligned/below-base accesses and add the align_err port.
module mem_stage_sram
  import mem_stage_sram_pkg::*;
#(
  parameter int unsigned BIT_NUMBER  = 32,
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_BASE   = ADDR_BASE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en,
  input  logic                  mem_w_en,
  input  logic [3:0]            dest_in,
  input  logic [BIT_NUMBER-1:0] alu_result,
  input  logic [BIT_NUMBER-1:0] val_rm,
  output logic                  freeze,
  output logic                  wb_en,
  output logic                  mem_r_en_out,
  output logic [3:0]            dest,
  output logic [BIT_NUMBER-1:0] alu_result_out,
  output logic [BIT_NUMBER-1:0] mem_data,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                  align_err,
`endif
  mem_stage_sram_if.master      sram
);

  logic                   mem_op_c;
  logic                   bad_c;
  logic                   req_c;
  logic                   done_c;
  logic [BIT_NUMBER-1:0]  offset_c;
  logic [SRAM_ADDR_W-2:0] word_c;
  logic [SRAM_WORD_W-1:0] rdata;
  logic                   unused_offset_bits;

  wb_ctrl_t               wb_q;
  logic [BIT_NUMBER-1:0]  alu_q;
  logic [BIT_NUMBER-1:0]  data_q;

  assign mem_op_c = mem_r_en | mem_w_en;

`ifdef MEM_ALIGN_CHECK_EN
  assign bad_c = mem_op_c & ((alu_result[1:0] != 2'b00) |
                             (alu_result < BIT_NUMBER'(ADDR_BASE)));
`else
  assign bad_c = 1'b0;
`endif

  assign req_c  = mem_op_c & !bad_c;
  assign freeze = req_c & !done_c & !rst;

  // Byte offset from the SRAM window, wrapped; bits [1:0] select a byte and are dropped.
  assign offset_c           = alu_result - BIT_NUMBER'(ADDR_BASE);
  assign word_c             = offset_c[SRAM_ADDR_W:2];
  assign unused_offset_bits = ^{offset_c[BIT_NUMBER-1:SRAM_ADDR_W+1], offset_c[1:0]};

  mem_stage_sram_word_ctrl #(
    .SRAM_ADDR_W (SRAM_ADDR_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_ctrl (
    .clk    (clk),
    .rst    (rst),
    .start  (req_c),
    .write  (mem_w_en),
    .word   (word_c),
    .wdata  (SRAM_WORD_W'(val_rm)),
    .done_c (done_c),
    .rdata  (rdata),
    .sram   (sram)
  );

  // WB registers: bubble while frozen, otherwise take the instruction (and load word in DONE).
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q   <= '0;
      alu_q  <= '0;
      data_q <= '0;
    end else if (freeze) begin
      wb_q.wb_en    <= 1'b0;
      wb_q.mem_r_en <= 1'b0;
    end else begin
      wb_q.wb_en    <= wb_en_in & !bad_c;
      wb_q.mem_r_en <= mem_r_en & !bad_c;
      wb_q.dest     <= dest_in;
      alu_q         <= alu_result;
      if (done_c) data_q <= BIT_NUMBER'(rdata);
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic align_q;

  always_ff @(posedge clk) begin
    if (rst) align_q <= 1'b0;
    else     align_q <= bad_c;
  end

  assign align_err = align_q;
`endif

  assign wb_en          = wb_q.wb_en;
  assign mem_r_en_out   = wb_q.mem_r_en;
  assign dest           = wb_q.dest;
  assign alu_result_out = alu_q;
  assign mem_data       = data_q;

endmodule

// File: tb/tb_mem_stage_sram.sv
// Scoreboard bench for mem_stage_sram: dut0 with WAIT_CYCLES=1, dut1 with WAIT_CYCLES=0.
module tb_mem_stage_sram;
  import mem_stage_sram_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [1:0]       wb_in, rd_in, wr_in, issue;
  logic [1:0][3:0]  dest_in;
  logic [1:0][31:0] alu_in, rm_in;
  wire  [1:0]       freeze_o, wb_o, rd_o;
  wire  [1:0][3:0]  dest_o;
  wire  [1:0][31:0] alu_o, data_o;
`ifdef MEM_ALIGN_CHECK_EN
  wire  [1:0]       aerr_o;
`endif

  mem_stage_sram_if #(.ADDR_W(18)) sif0 ();
  mem_stage_sram_if #(.ADDR_W(18)) sif1 ();

  mem_stage_sram #(.BIT_NUMBER(32), .SRAM_ADDR_W(18), .WAIT_CYCLES(1), .ADDR_BASE(1024)) dut0 (
    .clk(clk), .rst(rst), .wb_en_in(wb_in[0]), .mem_r_en(rd_in[0]), .mem_w_en(wr_in[0]),
    .dest_in(dest_in[0]), .alu_result(alu_in[0]), .val_rm(rm_in[0]), .freeze(freeze_o[0]),
    .wb_en(wb_o[0]), .mem_r_en_out(rd_o[0]), .dest(dest_o[0]), .alu_result_out(alu_o[0]),
    .mem_data(data_o[0]),
`ifdef MEM_ALIGN_CHECK_EN
    .align_err(aerr_o[0]),
`endif
    .sram(sif0)
  );

  mem_stage_sram #(.BIT_NUMBER(32), .SRAM_ADDR_W(18), .WAIT_CYCLES(0), .ADDR_BASE(1024)) dut1 (
    .clk(clk), .rst(rst), .wb_en_in(wb_in[1]), .mem_r_en(rd_in[1]), .mem_w_en(wr_in[1]),
    .dest_in(dest_in[1]), .alu_result(alu_in[1]), .val_rm(rm_in[1]), .freeze(freeze_o[1]),
    .wb_en(wb_o[1]), .mem_r_en_out(rd_o[1]), .dest(dest_o[1]), .alu_result_out(alu_o[1]),
    .mem_data(data_o[1]),
`ifdef MEM_ALIGN_CHECK_EN
    .align_err(aerr_o[1]),
`endif
    .sram(sif1)
  );

  // Behavioural SRAMs: write on a clock edge while strobed, read data always valid.
  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];

  always @(posedge clk)
    if (!sif0.sram_we_n && sif0.sram_dq_oe) mem0[sif0.sram_addr[7:0]] <= sif0.sram_dq_out;
  always @(posedge clk)
    if (!sif1.sram_we_n && sif1.sram_dq_oe) mem1[sif1.sram_addr[7:0]] <= sif1.sram_dq_out;

  assign sif0.sram_dq_in = mem0[sif0.sram_addr[7:0]];
  assign sif1.sram_dq_in = mem1[sif1.sram_addr[7:0]];

  typedef struct packed {
    logic        wb;
    logic        rd;
    logic [3:0]  dest;
    logic [31:0] alu;
    logic [31:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;

  // An instruction retires on an edge where it was presented and the stage was not frozen.
  logic [1:0] fire_q = '0;
  logic [1:0] frz_q  = '0;
  always @(posedge clk) begin
    fire_q <= issue & ~freeze_o & {2{~rst}};
    frz_q  <= freeze_o & {2{~rst}};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (fire_q[d]) begin
          exp_t e;
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL dut%0d scoreboard: output seen, no expected entry", d);
          end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("dut%0d wb_en", d),          32'(wb_o[d]), 32'(e.wb));
            chk($sformatf("dut%0d mem_r_en_out", d),   32'(rd_o[d]), 32'(e.rd));
            chk($sformatf("dut%0d dest", d),           32'(dest_o[d]), 32'(e.dest));
            chk($sformatf("dut%0d alu_result_out", d), alu_o[d], e.alu);
            if (e.rd) chk($sformatf("dut%0d mem_data", d), data_o[d], e.data);
          end
        end else if (frz_q[d]) begin
          chk($sformatf("dut%0d bubble wb_en", d),    32'(wb_o[d]), 32'd0);
          chk($sformatf("dut%0d bubble mem_r_en", d), 32'(rd_o[d]), 32'd0);
        end
      end
    end
  endtask

  task automatic issue_op(input int d, input logic wb, input logic rd, input logic wr,
                          input logic [3:0] dst, input logic [31:0] alu, input logic [31:0] rm,
                          input logic exp_wb, input logic exp_rd, input logic [31:0] exp_data,
                          input int exp_frz);
    exp_t e;
    int   nfrz;
    logic seen;
    @(negedge clk);
    wb_in[d] = wb; rd_in[d] = rd; wr_in[d] = wr;
    dest_in[d] = dst; alu_in[d] = alu; rm_in[d] = rm; issue[d] = 1'b1;
    e = '{wb: exp_wb, rd: exp_rd, dest: dst, alu: alu, data: exp_data};
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    nfrz = 0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      #1;
      if (!freeze_o[d]) seen = 1'b1;
      else begin
        nfrz++;
        @(negedge clk);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL dut%0d freeze timeout: still high after %0d cycles, required %0d", d, nfrz, exp_frz);
    end else begin
      chk($sformatf("dut%0d freeze cycles", d), 32'(nfrz), 32'(exp_frz));
    end
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    wb_in[d] = 1'b0; rd_in[d] = 1'b0; wr_in[d] = 1'b0;
    dest_in[d] = '0; alu_in[d] = '0; rm_in[d] = '0; issue[d] = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [17:0] addr_snap;
    rst = 1'b1;
    wb_in = '0; rd_in = '0; wr_in = '0; issue = '0;
    dest_in = '0; alu_in = '0; rm_in = '0;
    fork
      monitor();
    join_none

    // Reset values
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d rst wb_en", d),    32'(wb_o[d]), 32'd0);
      chk($sformatf("dut%0d rst mem_r_en", d), 32'(rd_o[d]), 32'd0);
      chk($sformatf("dut%0d rst dest", d),     32'(dest_o[d]), 32'd0);
      chk($sformatf("dut%0d rst alu_out", d),  alu_o[d], 32'd0);
      chk($sformatf("dut%0d rst mem_data", d), data_o[d], 32'd0);
      chk($sformatf("dut%0d rst freeze", d),   32'(freeze_o[d]), 32'd0);
    end
    chk("rst sram_addr", 32'(sif0.sram_addr), 32'd0);
    chk("rst sram_we_n", 32'(sif0.sram_we_n), 32'd1);
    chk("rst sram_oe",   32'(sif0.sram_dq_oe), 32'd0);
    chk("rst sram_dq",   32'(sif0.sram_dq_out), 32'd0);

    // Reset in the middle of the high half of a write (1056 -> half-words 16/17)
    @(negedge clk);
    wr_in[0] = 1'b1; alu_in[0] = 32'd1056; rm_in[0] = 32'hA5A5_5A5A; dest_in[0] = 4'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("midhi sram_we_n", 32'(sif0.sram_we_n), 32'd0);
    chk("midhi sram_addr", 32'(sif0.sram_addr), 32'd17);
    rst = 1'b1;
    #1;
    chk("rst gates freeze", 32'(freeze_o[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wr_in[0] = 1'b0; alu_in[0] = '0; rm_in[0] = '0; dest_in[0] = '0;
    #1;
    chk("abort state",     32'(dut0.u_ctrl.state), 32'(S_IDLE));
    chk("abort sram_we_n", 32'(sif0.sram_we_n), 32'd1);
    chk("abort sram_oe",   32'(sif0.sram_dq_oe), 32'd0);
    chk("abort freeze",    32'(freeze_o[0]), 32'd0);
    chk("abort wb_en",     32'(wb_o[0]), 32'd0);
    chk("abort low half kept", 32'(mem0[16]), 32'h5A5A);

    // Non-memory pass-through
    issue_op(0, 1'b1, 1'b0, 1'b0, 4'd3,  32'h55,        32'h0,    1'b1, 1'b0, 32'h0, 0);
    issue_op(0, 1'b1, 1'b0, 1'b0, 4'hF,  32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0, 32'h0, 0);
    idle(0);

    // STR 0xDEADBEEF at 1028, W=1
    issue_op(0, 1'b0, 1'b0, 1'b1, 4'd5, 32'd1028, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 5);
    idle(0);
    #1;
    chk("str lo half @2", 32'(mem0[2]), 32'hBEEF);
    chk("str hi half @3", 32'(mem0[3]), 32'hDEAD);
    chk("str we_n after", 32'(sif0.sram_we_n), 32'd1);

    // LDR 1028, W=1; plus address aliasing and ignored byte bits
    issue_op(0, 1'b1, 1'b1, 1'b0, 4'd7, 32'd1028, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 5);
`ifndef MEM_ALIGN_CHECK_EN
    issue_op(0, 1'b1, 1'b1, 1'b0, 4'd8, 32'd525316, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 5);
    issue_op(0, 1'b1, 1'b1, 1'b0, 4'd9, 32'd1031,   32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 5);
`endif
    issue_op(0, 1'b1, 1'b0, 1'b0, 4'd10, 32'h0000_0ABC, 32'h0, 1'b1, 1'b0, 32'h0, 0);
    idle(0);

    // W=0: two stores then back-to-back loads
    issue_op(1, 1'b0, 1'b0, 1'b1, 4'd1, 32'd1024, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 3);
    issue_op(1, 1'b0, 1'b0, 1'b1, 4'd2, 32'd1032, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 3);
    issue_op(1, 1'b1, 1'b1, 1'b0, 4'd3, 32'd1032, 32'h0, 1'b1, 1'b1, 32'hCAFE_F00D, 3);
    issue_op(1, 1'b1, 1'b1, 1'b0, 4'd4, 32'd1024, 32'h0, 1'b1, 1'b1, 32'h1234_5678, 3);
    issue_op(1, 1'b1, 1'b0, 1'b0, 4'd6, 32'h0000_0DEF, 32'h0, 1'b1, 1'b0, 32'h0, 0);
    idle(1);
    #1;
    chk("w0 mem @0", 32'(mem1[0]), 32'h5678);
    chk("w0 mem @1", 32'(mem1[1]), 32'h1234);
    chk("w0 mem @4", 32'(mem1[4]), 32'hF00D);
    chk("w0 mem @5", 32'(mem1[5]), 32'hCAFE);

`ifdef MEM_ALIGN_CHECK_EN
    // Rejected accesses: unaligned LDR and below-base STR
    addr_snap = sif0.sram_addr;
    issue_op(0, 1'b1, 1'b1, 1'b0, 4'd2, 32'd1030, 32'h0, 1'b0, 1'b0, 32'h0, 0);
    idle(0);
    #1;
    chk("align_err pulse", 32'(aerr_o[0]), 32'd1);
    chk("align sram_addr", 32'(sif0.sram_addr), 32'(addr_snap));
    @(negedge clk);
    #1;
    chk("align_err clear", 32'(aerr_o[0]), 32'd0);
    issue_op(0, 1'b0, 1'b0, 1'b1, 4'd1, 32'd1020, 32'h1111_2222, 1'b0, 1'b0, 32'h0, 0);
    idle(0);
    #1;
    chk("below-base align_err", 32'(aerr_o[0]), 32'd1);
    chk("below-base we_n",      32'(sif0.sram_we_n), 32'd1);
    chk("below-base sram_addr", 32'(sif0.sram_addr), 32'(addr_snap));
`else
    addr_snap = '0;
`endif

    repeat (3) @(negedge clk);
    chk("dut0 scoreboard drained", 32'(q0.size()), 32'd0);
    chk("dut1 scoreboard drained", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
